// File: rtl/echo_capture_buffer_pkg.sv
// ----------------------------------------------------------------------------
// echo_capture_buffer_pkg
//   Shared definitions for the receive-side echo capture path. The sample
//   width default is common to the transmit FSM and the UART blocks, so it
//   lives here rather than in each module.
//   Contents:
//     SAMPLE_W_DEFAULT - ADC sample width, one UART byte per sample
//     state_t          - capture buffer controller states
// ----------------------------------------------------------------------------
package echo_capture_buffer_pkg;

  localparam int SAMPLE_W_DEFAULT = 8;

  // IDLE waits for the AFE to switch to receive, SETTLE rides out the
  // switch transient, CAPTURE records samples, DRAIN streams them to the
  // UART, and CLEAR empties the buffer and tells the transmit FSM to go on.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CLEAR   = 3'd4
  } state_t;

endpackage

// File: rtl/echo_sample_ram.sv
// ----------------------------------------------------------------------------
// echo_sample_ram
//   Simple dual-port sample memory, DEPTH x SAMPLE_W, with one write port and
//   one registered read port (data appears one clock after the address).
//   Written so that synthesis maps it onto block RAM: no reset on the array
//   or on the read register.
//   Ports:
//     i_clk    in  1         clock, rising edge
//     i_we     in  1         write enable
//     i_waddr  in  ADDR_W    write address
//     i_wdata  in  SAMPLE_W  write data
//     i_raddr  in  ADDR_W    read address
//     o_rdata  out SAMPLE_W  read data, mem[i_raddr] from the previous cycle
// ----------------------------------------------------------------------------
module echo_sample_ram
  import echo_capture_buffer_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 9
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [SAMPLE_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [SAMPLE_W-1:0] o_rdata
);

  logic [SAMPLE_W-1:0] r_mem [DEPTH];
  logic [SAMPLE_W-1:0] r_rdata;

  // Write and registered read share the clock. A read of an address being
  // written in the same cycle returns the old contents; the controller never
  // relies on that case.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_capture_buffer.sv
// ----------------------------------------------------------------------------
// echo_capture_buffer
//   Receive-side stage after the image transmit FSM. When the AFE switches to
//   receive it waits out the switch transient, records ADC echo samples into
//   on-chip RAM, then streams them byte by byte to the UART transmitter. When
//   the buffer is drained it pulses o_mem_clear so the transmit FSM can fire
//   the next line.
//   Ports:
//     i_clk          in  1         system clock, rising edge
//     i_rst          in  1         synchronous reset, active low
//     i_afe_switch   in  1         1 = AFE in receive path
//     i_adc_data     in  SAMPLE_W  ADC sample
//     i_adc_valid    in  1         i_adc_data valid this cycle
//     i_tx_ready     in  1         UART idle and able to take a byte
//     o_tx_data      out SAMPLE_W  byte to UART, stable while o_tx_start=1
//     o_tx_start     out 1         one-cycle send request
//     o_capturing    out 1         1 while capturing samples
//     o_sample_count out ADDR_W+1  samples stored for the current line
//     o_mem_clear    out 1         one-cycle pulse: buffer drained and emptied
//     o_busy         out 1         1 whenever not idle
// ----------------------------------------------------------------------------
module echo_capture_buffer
  import echo_capture_buffer_pkg::*;
#(
  parameter int SAMPLE_W      = SAMPLE_W_DEFAULT,
  parameter int DEPTH         = 512,
  parameter int ADDR_W        = 9,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_afe_switch,
  input  logic [SAMPLE_W-1:0] i_adc_data,
  input  logic                i_adc_valid,
  input  logic                i_tx_ready,
  output logic [SAMPLE_W-1:0] o_tx_data,
  output logic                o_tx_start,
  output logic                o_capturing,
  output logic [ADDR_W:0]     o_sample_count,
  output logic                o_mem_clear,
  output logic                o_busy
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W:0]     COUNT_LAST  = (ADDR_W+1)'(DEPTH - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic                r_afeSwitchQ;
  logic [SETTLE_W-1:0] r_settleCount;
  logic [ADDR_W-1:0]   r_wrPtr;
  logic [ADDR_W:0]     r_rdPtr;
  logic [ADDR_W:0]     r_sampleCount;
  logic [SAMPLE_W-1:0] r_txData;
  logic                r_txStart;
  logic                r_loaded;
  logic                r_rdValid;
  logic [SAMPLE_W-1:0] w_ramRdata;
  logic                w_switchRise;
  logic                w_lastWrite;
  logic                w_write;
  logic                w_load;
  logic                w_fire;
  logic                w_drained;

  // Sample memory. The read address always follows the drain pointer so the
  // next byte is already sitting on the RAM output when it is needed.
  echo_sample_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_write),
    .i_waddr (r_wrPtr),
    .i_wdata (i_adc_data),
    .i_raddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdata (w_ramRdata)
  );

  // Handshake and datapath decode. A sample offered while the AFE drops is
  // normally discarded, except when it is the one that fills the buffer.
  // A byte is loaded into o_tx_data only when the previous one has been
  // launched, so the byte on o_tx_data never changes under o_tx_start. A new
  // launch is refused while o_tx_start is high, which forces the gap cycle.
  // The line is finished once every byte is launched and the UART reports
  // ready again after the gap.
  always_comb begin
    w_switchRise = 1'b0;
    w_lastWrite  = 1'b0;
    w_write      = 1'b0;
    w_load       = 1'b0;
    w_fire       = 1'b0;
    w_drained    = 1'b0;
    w_switchRise = !r_afeSwitchQ && i_afe_switch;
    w_lastWrite  = (r_sampleCount == COUNT_LAST);
    w_write      = (r_state == ST_CAPTURE) && i_adc_valid &&
                   (i_afe_switch || w_lastWrite);
    w_load       = (r_state == ST_DRAIN) && r_rdValid && !r_loaded &&
                   (r_rdPtr < r_sampleCount);
    w_fire       = (r_state == ST_DRAIN) && r_loaded && i_tx_ready && !r_txStart;
    w_drained    = (r_rdPtr == r_sampleCount) && !r_loaded && !r_txStart;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and state-decoded outputs. A line that ends with no
  // samples skips DRAIN and goes straight to CLEAR so the transmit FSM still
  // gets its mem_clear pulse.
  always_comb begin
    w_nextState = r_state;
    o_capturing = 1'b0;
    o_mem_clear = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (w_switchRise) begin
          w_nextState = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!i_afe_switch) begin
          w_nextState = ST_CLEAR;
        end else if (r_settleCount == SETTLE_LAST) begin
          w_nextState = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        o_capturing = 1'b1;
        if (w_write && w_lastWrite) begin
          w_nextState = ST_DRAIN;
        end else if (!i_afe_switch) begin
          w_nextState = (r_sampleCount == '0) ? ST_CLEAR : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_sampleCount == '0) begin
          w_nextState = ST_CLEAR;
        end else if (w_drained && i_tx_ready) begin
          w_nextState = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        o_mem_clear = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Settle counter, pointers and the UART byte register. r_rdValid marks
  // that the RAM output already reflects the current drain pointer: it drops
  // for one cycle every time the pointer moves and is held low outside DRAIN
  // so a stale read from capture time is never loaded.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_afeSwitchQ  <= 1'b0;
      r_settleCount <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_sampleCount <= '0;
      r_txData      <= '0;
      r_txStart     <= 1'b0;
      r_loaded      <= 1'b0;
      r_rdValid     <= 1'b0;
    end else begin
      r_afeSwitchQ <= i_afe_switch;
      r_txStart    <= w_fire;
      r_rdValid    <= (r_state == ST_DRAIN) && !w_load;

      if (r_state == ST_SETTLE) begin
        r_settleCount <= r_settleCount + SETTLE_W'(1);
      end else begin
        r_settleCount <= '0;
      end

      if (w_write) begin
        r_wrPtr       <= r_wrPtr + ADDR_W'(1);
        r_sampleCount <= r_sampleCount + (ADDR_W+1)'(1);
      end

      if (w_load) begin
        r_txData <= w_ramRdata;
        r_loaded <= 1'b1;
        r_rdPtr  <= r_rdPtr + (ADDR_W+1)'(1);
      end else if (w_fire) begin
        r_loaded <= 1'b0;
      end

      if (r_state == ST_CLEAR) begin
        r_wrPtr       <= '0;
        r_rdPtr       <= '0;
        r_sampleCount <= '0;
        r_loaded      <= 1'b0;
      end
    end
  end

  assign o_tx_data      = r_txData;
  assign o_tx_start     = r_txStart;
  assign o_sample_count = r_sampleCount;

endmodule

// File: tb/tb_echo_capture_buffer.sv
// ----------------------------------------------------------------------------
// tb_echo_capture_buffer
//   Two instances share the stimulus: dutA with the full 512-deep buffer and
//   dutB with an 8-deep buffer for the buffer-full corner. A cycle table
//   drives dutA through reset and a short line, then hand-written sequences
//   cover the longer multi-cycle cases. Monitors on the falling edge log every
//   byte launched and every mem_clear pulse.
// ----------------------------------------------------------------------------
module tb_echo_capture_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       afe;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  logic [7:0] txDataA;
  logic       txStartA, capturingA, memClearA, busyA;
  logic [9:0] countA;
  logic [7:0] txDataB;
  logic       txStartB, capturingB, memClearB, busyB;
  logic [3:0] countB;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0] bytesA[$];
  int         cycA[$];
  int         clrA = 0;
  logic [7:0] bytesB[$];
  int         clrB = 0;

  typedef struct {
    logic       rst;
    logic       afe;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       expBusy;
    logic       expCapt;
    int         expCount;
    logic       expStart;
    logic [7:0] expTxData;
    logic       expMemClear;
  } vec_t;

  vec_t vecs[$];

  echo_capture_buffer #(
    .SAMPLE_W(8), .DEPTH(512), .ADDR_W(9), .SETTLE_CYCLES(4)
  ) dutA (
    .i_clk(clk), .i_rst(rst), .i_afe_switch(afe), .i_adc_data(data),
    .i_adc_valid(valid), .i_tx_ready(ready), .o_tx_data(txDataA),
    .o_tx_start(txStartA), .o_capturing(capturingA), .o_sample_count(countA),
    .o_mem_clear(memClearA), .o_busy(busyA)
  );

  echo_capture_buffer #(
    .SAMPLE_W(8), .DEPTH(8), .ADDR_W(3), .SETTLE_CYCLES(4)
  ) dutB (
    .i_clk(clk), .i_rst(rst), .i_afe_switch(afe), .i_adc_data(data),
    .i_adc_valid(valid), .i_tx_ready(ready), .o_tx_data(txDataB),
    .o_tx_start(txStartB), .o_capturing(capturingB), .o_sample_count(countB),
    .o_mem_clear(memClearB), .o_busy(busyB)
  );

  always #5 clk = ~clk;

  // Free-running cycle number, used to measure spacing between launches.
  always @(posedge clk) cycle <= cycle + 1;

  // Byte and mem_clear logging, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (txStartA) begin
      bytesA.push_back(txDataA);
      cycA.push_back(cycle);
    end
    if (memClearA) clrA++;
    if (txStartB) bytesB.push_back(txDataB);
    if (memClearB) clrB++;
  end

  function automatic vec_t mkVec(input logic r, a, v, input logic [7:0] d,
                                 input logic rd, input logic eb, ec,
                                 input int cnt, input logic es,
                                 input logic [7:0] ed, input logic em);
    vec_t x;
    x.rst = r; x.afe = a; x.valid = v; x.data = d; x.ready = rd;
    x.expBusy = eb; x.expCapt = ec; x.expCount = cnt; x.expStart = es;
    x.expTxData = ed; x.expMemClear = em;
    return x;
  endfunction

  // Drive one cycle of inputs, then move to just after the next rising edge.
  task automatic applyStimulus(input logic r, a, v, input logic [7:0] d,
                               input logic rd);
    rst = r; afe = a; valid = v; data = d; ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic resetDuts();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  // Rise cycle followed by the four settle cycles; both DUTs end in capture.
  task automatic startLine();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic waitClear(input bit useB, input logic a, input int budget,
                           input string name);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      applyStimulus(1'b1, a, 1'b0, 8'h00, 1'b1);
      if (useB ? memClearB : memClearA) seen = 1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic waitStartA(input int budget, input string name);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      if (txStartA) seen = 1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int base;
    int clrBase;
    rst = 1'b0; afe = 1'b0; valid = 1'b0; data = 8'h00; ready = 1'b1;

    // Reset with samples offered, then a two-sample line whose first
    // samples arrive during settle; traced cycle by cycle on dutA.
    vecs.push_back(mkVec(0,0,1,8'hAA,1, 0,0,0,0,8'h00,0));
    vecs.push_back(mkVec(0,0,1,8'hAA,1, 0,0,0,0,8'h00,0));
    vecs.push_back(mkVec(1,0,1,8'hAA,1, 0,0,0,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'hFF,1, 1,0,0,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'hFF,1, 1,0,0,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'hFF,1, 1,0,0,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'hFF,1, 1,0,0,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'hFF,1, 1,1,0,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'h11,1, 1,1,1,0,8'h00,0));
    vecs.push_back(mkVec(1,1,1,8'h22,1, 1,1,2,0,8'h00,0));
    vecs.push_back(mkVec(1,0,1,8'h33,1, 1,0,2,0,8'h00,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,0,8'h00,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,0,8'h11,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,1,8'h11,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,0,8'h22,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,1,8'h22,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,0,8'h22,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 1,0,2,0,8'h22,1));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 0,0,0,0,8'h22,0));
    vecs.push_back(mkVec(1,0,0,8'h00,1, 0,0,0,0,8'h22,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].afe, vecs[i].valid, vecs[i].data,
                    vecs[i].ready);
      checkOutput($sformatf("vec%0d busy", i), 32'(busyA), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d capturing", i), 32'(capturingA),
                  32'(vecs[i].expCapt));
      checkOutput($sformatf("vec%0d count", i), 32'(countA),
                  32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d tx_start", i), 32'(txStartA),
                  32'(vecs[i].expStart));
      checkOutput($sformatf("vec%0d tx_data", i), 32'(txDataA),
                  32'(vecs[i].expTxData));
      checkOutput($sformatf("vec%0d mem_clear", i), 32'(memClearA),
                  32'(vecs[i].expMemClear));
    end

    // Nominal 16-byte line with the UART always ready.
    resetDuts();
    base = bytesA.size();
    clrBase = clrA;
    startLine();
    checkOutput("nom capturing", 32'(capturingA), 32'd1);
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(i), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("nom count", 32'(countA), 32'd16);
    waitClear(1'b0, 1'b0, 100, "nom mem_clear seen");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("nom count cleared", 32'(countA), 32'd0);
    checkOutput("nom busy", 32'(busyA), 32'd0);
    checkOutput("nom clear pulses", 32'(clrA - clrBase), 32'd1);
    checkOutput("nom byte total", 32'(bytesA.size() - base), 32'd16);
    if (bytesA.size() - base == 16) begin
      for (int i = 0; i < 16; i++) begin
        checkOutput($sformatf("nom byte%0d", i), 32'(bytesA[base+i]), 32'(i+1));
        if (i > 0)
          checkOutput($sformatf("nom gap%0d", i),
                      32'(cycA[base+i] - cycA[base+i-1]), 32'd2);
      end
    end

    // Buffer full on dutB: 20 samples offered, only 8 kept.
    resetDuts();
    base = bytesB.size();
    clrBase = clrB;
    startLine();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 1'b1);
      checkOutput($sformatf("full capturing%0d", i), 32'(capturingB),
                  32'(i < 7));
      checkOutput($sformatf("full count%0d", i), 32'(countB),
                  32'((i < 8) ? i + 1 : 8));
    end
    waitClear(1'b1, 1'b1, 100, "full mem_clear seen");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("full busy", 32'(busyB), 32'd0);
    checkOutput("full clear pulses", 32'(clrB - clrBase), 32'd1);
    checkOutput("full byte total", 32'(bytesB.size() - base), 32'd8);
    if (bytesB.size() - base == 8) begin
      for (int i = 0; i < 8; i++)
        checkOutput($sformatf("full byte%0d", i), 32'(bytesB[base+i]),
                    32'(8'h40 + i));
    end

    // Backpressure: UART busy for ten cycles after the first byte.
    resetDuts();
    base = bytesA.size();
    startLine();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hB2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC3, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    waitStartA(20, "bp first start seen");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("bp start low%0d", k), 32'(txStartA), 32'd0);
      checkOutput($sformatf("bp data held%0d", k), 32'(txDataA), 32'hB2);
    end
    waitClear(1'b0, 1'b0, 50, "bp mem_clear seen");
    checkOutput("bp byte total", 32'(bytesA.size() - base), 32'd3);
    if (bytesA.size() - base == 3) begin
      checkOutput("bp byte0", 32'(bytesA[base]),   32'hA1);
      checkOutput("bp byte1", 32'(bytesA[base+1]), 32'hB2);
      checkOutput("bp byte2", 32'(bytesA[base+2]), 32'hC3);
    end

    // Switch drops during settle: empty line still reports mem_clear.
    resetDuts();
    base = bytesA.size();
    clrBase = clrA;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
    checkOutput("empty mem_clear", 32'(memClearA), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("empty busy", 32'(busyA), 32'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("empty no bytes", 32'(bytesA.size() - base), 32'd0);
    checkOutput("empty clear pulses", 32'(clrA - clrBase), 32'd1);

    // Reset in the middle of draining abandons the line.
    resetDuts();
    base = bytesA.size();
    clrBase = clrA;
    startLine();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'h70 + i), 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    waitStartA(20, "rst first start seen");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("rst busy", 32'(busyA), 32'd0);
    checkOutput("rst tx_start", 32'(txStartA), 32'd0);
    checkOutput("rst count", 32'(countA), 32'd0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("rst bytes", 32'(bytesA.size() - base), 32'd1);
    checkOutput("rst no clear", 32'(clrA - clrBase), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
